// File: rtl/mult_exe_unit.sv
// Iterative signed shift-add multiplier for the EXE stage. It stalls the pipeline
// with freeze while a multiply is running and writes the 2*WORD_LEN-bit product to HI/LO.
module mult_exe_unit #(
  parameter int                     WORD_LEN    = 32,
  parameter int                     EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] EXE_MULT    = EXE_CMD_LEN'(12)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
  input  logic [WORD_LEN-1:0]    val1,
  input  logic [WORD_LEN-1:0]    val2,
  output logic                   freeze,
  output logic                   done,
  output logic [WORD_LEN-1:0]    hi,
  output logic [WORD_LEN-1:0]    lo
);

  // state  | meaning
  // S_IDLE | waiting for EXE_MULT, HI/LO stable
  // S_RUN  | one multiplier bit per edge, LSB first
  // S_FIX  | apply sign, write HI/LO, pulse done next cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int                CNT_W    = $clog2(WORD_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_LEN - 1);

  logic [1:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [WORD_LEN-1:0]   mcand_q,  mcand_d;
  logic [WORD_LEN-1:0]   mplier_q, mplier_d;
  logic                  sign_q,   sign_d;
  logic [2*WORD_LEN-1:0] acc_q,    acc_d;
  logic [WORD_LEN-1:0]   hi_q,     hi_d;
  logic [WORD_LEN-1:0]   lo_q,     lo_d;
  logic                  done_q,   done_d;

  logic [WORD_LEN-1:0]   abs1, abs2;
  logic [WORD_LEN:0]     add_sum;
  logic [2*WORD_LEN-1:0] fix_res;

  // Unsigned magnitude; -2^(WORD_LEN-1) maps onto itself, which is correct unsigned.
  assign abs1 = val1[WORD_LEN-1] ? (~val1 + WORD_LEN'(1)) : val1;
  assign abs2 = val2[WORD_LEN-1] ? (~val2 + WORD_LEN'(1)) : val2;

  // Carry out of the upper-half add becomes the new MSB after the shift.
  assign add_sum = {1'b0, acc_q[2*WORD_LEN-1:WORD_LEN]}
                 + (mplier_q[0] ? {1'b0, mcand_q} : {(WORD_LEN+1){1'b0}});

  assign fix_res = sign_q ? (~acc_q + (2*WORD_LEN)'(1)) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EXE_CMD == EXE_MULT) begin
          mcand_d  = abs1;
          mplier_d = abs2;
          sign_d   = val1[WORD_LEN-1] ^ val2[WORD_LEN-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = {add_sum, acc_q[WORD_LEN-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = fix_res;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign freeze = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_mult_exe_unit.sv
// Scoreboard bench for mult_exe_unit: expected products are queued at issue
// and compared when done pulses; freeze/done timing is checked cycle by cycle.
module tb_mult_exe_unit;

  localparam logic [3:0] EXE_ADD          = 4'd0;
  localparam logic [3:0] EXE_SUB          = 4'd2;
  localparam logic [3:0] EXE_NO_OPERATION = 4'hF;
  localparam logic [3:0] EXE_MULT         = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  EXE_CMD = 4'd0;
  logic [31:0] val1 = '0, val2 = '0;
  logic        freeze, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  mult_exe_unit #(.WORD_LEN(32), .EXE_CMD_LEN(4), .EXE_MULT(EXE_MULT)) dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2),
    .freeze(freeze), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Issue one MULT for a single cycle, then verify freeze length, hold of HI/LO and done.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
    int nf;
    logic [63:0] prev, got;
    @(negedge clk);
    prev = {hi, lo};
    EXE_CMD = EXE_MULT; val1 = a; val2 = b;
    sb.push_back(exp);
    @(negedge clk);
    EXE_CMD = EXE_NO_OPERATION; val1 = $urandom; val2 = $urandom;
    nf = 0;
    while (freeze === 1'b1 && nf < 100) begin
      nf++;
      if (nf == 20) begin
        n_cmp++;
        if ({hi, lo} !== prev) begin
          n_err++;
          $display("FAIL %s hold: hi_lo=%h required %h", name, {hi, lo}, prev);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nf != 33) begin
      n_err++;
      $display("FAIL %s freeze_len: got %0d required 33", name, nf);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done: got %b required 1", name, done);
    end else if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard: done with empty queue", name);
    end else begin
      got = sb.pop_front();
      if ({hi, lo} !== got) begin
        n_err++;
        $display("FAIL %s product: hi=%h lo=%h required hi=%h lo=%h",
                 name, hi, lo, got[63:32], got[31:0]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || freeze !== 1'b0) begin
      n_err++;
      $display("FAIL %s after: done=%b freeze=%b required 0 0", name, done, freeze);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({freeze, done, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset: freeze=%b done=%b hi=%h lo=%h required all 0", freeze, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({freeze, done, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_release: freeze=%b done=%b hi=%h lo=%h required all 0", freeze, done, hi, lo);
    end
  endtask

  task automatic test_products();
    run_mult(32'd7, 32'd6, 64'h00000000_0000002A, "7x6");
    run_mult(32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, "m3x5");
    run_mult(32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "minxm1");
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "m1xm1");
    run_mult(32'd0, 32'hFFFFFFF7, 64'h0, "0xm9");
    run_mult(32'h80000000, 32'h80000000, 64'h40000000_00000000, "minxmin");
    run_mult(32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, "maxxmin");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) a[31] = 1'b1;
      if (i == 1) b[31] = 1'b1;
      run_mult(a, b, model(a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0, first_at = -1, second_at = -1;
    bit check_next = 0;
    logic [63:0] got;
    @(negedge clk);
    EXE_CMD = EXE_MULT; val1 = 32'd3; val2 = 32'd4;
    sb.push_back(64'd12);
    sb.push_back(64'h00000001_00000000);
    @(negedge clk);
    val1 = 32'h00010000; val2 = 32'h00010000;
    for (int i = 1; i < 90; i++) begin
      if (check_next) begin
        check_next = 0;
        n_cmp++;
        if (freeze !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL b2b restart: freeze=%b done=%b required 1 0", freeze, done);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin first_at = i; check_next = 1; end
        if (n_done == 2) begin second_at = i; EXE_CMD = EXE_ADD; end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL b2b scoreboard: done with empty queue");
        end else begin
          got = sb.pop_front();
          if ({hi, lo} !== got) begin
            n_err++;
            $display("FAIL b2b product%0d: hi=%h lo=%h required hi=%h lo=%h",
                     n_done, hi, lo, got[63:32], got[31:0]);
          end
        end
      end
      @(negedge clk);
    end
    EXE_CMD = EXE_NO_OPERATION;
    n_cmp++;
    if (n_done != 2) begin
      n_err++;
      $display("FAIL b2b done_count: got %0d required 2", n_done);
    end
    n_cmp++;
    if (second_at - first_at != 34) begin
      n_err++;
      $display("FAIL b2b spacing: got %0d required 34", second_at - first_at);
    end
    n_cmp++;
    if (freeze !== 1'b0) begin
      n_err++;
      $display("FAIL b2b idle: freeze=%b required 0", freeze);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    EXE_CMD = EXE_MULT; val1 = 32'd1234; val2 = 32'd5678;
    @(negedge clk);
    EXE_CMD = EXE_NO_OPERATION;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({freeze, done, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL async_reset: freeze=%b done=%b hi=%h lo=%h required all 0", freeze, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (freeze !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset idle: freeze=%b done=%b required 0 0", freeze, done);
    end
    run_mult(32'd2, 32'd3, 64'd6, "post_reset");
  endtask

  task automatic test_non_mult();
    logic [63:0] prev;
    logic [3:0] cmds[4];
    bit bad = 0;
    cmds[0] = EXE_ADD; cmds[1] = EXE_SUB; cmds[2] = EXE_NO_OPERATION; cmds[3] = 4'd0;
    @(negedge clk);
    prev = {hi, lo};
    for (int i = 0; i < 50; i++) begin
      EXE_CMD = cmds[i % 4]; val1 = $urandom; val2 = $urandom;
      @(negedge clk);
      if (freeze !== 1'b0 || done !== 1'b0) begin
        if (!bad)
          $display("FAIL non_mult cycle %0d: freeze=%b done=%b required 0 0", i, freeze, done);
        bad = 1;
      end
    end
    n_cmp++;
    if (bad) n_err++;
    n_cmp++;
    if ({hi, lo} !== prev) begin
      n_err++;
      $display("FAIL non_mult hold: hi_lo=%h required %h", {hi, lo}, prev);
    end
    EXE_CMD = EXE_NO_OPERATION;
  endtask

  initial begin
    test_reset();
    test_products();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_non_mult();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_exe_unit.md
Name: mult_exe_unit

Overview:
- Iterative signed multiplier in the EXE stage, downstream of the decode controller.
- Starts when the ID/EXE register delivers an EXE_CMD of EXE_MULT.
- Computes the 2*WORD_LEN-bit product into dedicated HI/LO registers; MULT has no register-file writeback.
- Asserts freeze to the hazard/pipeline-register logic while busy, so later instructions hold in ID/EXE until the product is ready.

Parameters:
- WORD_LEN, 32: operand width in bits; HI and LO are each WORD_LEN bits.
- EXE_CMD_LEN, 4: width of the EXE_CMD field; must equal the codebase's `EXE_CMD_LEN`.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- EXE_CMD  in  EXE_CMD_LEN  command from the ID/EXE register; a start is decoded only for `EXE_MULT`
- val1  in  WORD_LEN  multiplicand, two's complement
- val2  in  WORD_LEN  multiplier, two's complement
- freeze  out  1  high while a multiply is in flight; stalls PC, IF/ID and ID/EXE
- done  out  1  one-cycle pulse on the cycle after HI/LO are updated
- hi  out  WORD_LEN  upper product word, registered
- lo  out  WORD_LEN  lower product word, registered

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, counter=0, internal magnitude/accumulator registers=0.
  - freeze=0, done=0, hi=0, lo=0.
  - A multiply in progress is abandoned; no partial result reaches hi/lo.
- States are IDLE, RUN and FIX. freeze = (state != IDLE), decoded combinationally from the state register.
- IDLE:
  - If EXE_CMD == `EXE_MULT` at a rising edge (E0), latch |val1|, |val2| and sign = val1[MSB] ^ val2[MSB].
  - Clear the 2*WORD_LEN accumulator and counter; go to RUN.
  - Any other EXE_CMD leaves the unit idle. Hazard bubbles arrive as EXE_CMD=0 and never start it.
- RUN, one multiplier bit per edge, LSB first (shift-add):
  - If the current multiplier bit is 1, add the multiplicand magnitude into the upper half of the accumulator.
  - Shift accumulator and multiplier right by 1. The add carry is kept, so the accumulator is WORD_LEN+1 bits wide internally at the top.
  - Counter increments; after the WORD_LEN-th RUN edge (E32 at default), go to FIX.
- FIX, one edge (E33 at default):
  - {hi,lo} = sign ? two's-complement negation of the accumulator : accumulator.
  - done=1 for exactly the following cycle; go to IDLE.
- Latency and stall:
  - freeze is high for WORD_LEN+1 cycles (after E0 through E33), and done follows E33.
  - hi/lo hold the previous product until E33, then hold the new product until the next FIX or reset.
- Inputs outside IDLE:
  - EXE_CMD/val1/val2 are ignored in RUN and FIX.
  - A second MULT held in ID/EXE by freeze is accepted at the first edge with state=IDLE, i.e. the edge after done asserts. Back-to-back spacing is therefore WORD_LEN+2 edges between starts.
- Arithmetic:
  - The magnitude of the most negative value (2^(WORD_LEN-1)) is representable unsigned in WORD_LEN bits and must be handled without overflow.
  - A zero product with sign=1 must yield hi=lo=0 (negation of 0 is 0).
- No other commands alter hi/lo. The unit does not read the branch, memory or WB_EN controls.

Test Plan:
- Reset, then EXE_CMD=`EXE_MULT`, val1=7, val2=6 for one cycle -> freeze high 33 cycles; done pulses once after E33; hi=0x00000000, lo=0x0000002A.
- val1=-3 (0xFFFFFFFD), val2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Corner operands, checked for both overflow and sign handling:
  - val1=0x80000000, val2=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
  - val1=0xFFFFFFFF, val2=0xFFFFFFFF -> hi=0, lo=1.
  - val1=0, val2=-9 -> hi=lo=0.
- Two MULTs with EXE_CMD held at `EXE_MULT` through the freeze (3*4, then 0x10000*0x10000) -> first product hi=0, lo=12; second starts the edge after the first done; final hi=0x00000001, lo=0; exactly two done pulses.
- Assert rst=0 asynchronously mid-RUN (e.g. 10 cycles after start), release -> freeze/done/hi/lo are 0 immediately, with no clock edge needed; unit is IDLE; a new MULT 2*3 completes with lo=6.
- Non-MULT commands (`EXE_ADD`, `EXE_SUB`, `EXE_NO_OPERATION`, 0) presented for 50 cycles -> freeze never asserts; done stays 0; hi/lo unchanged.
